// File: rtl/logb_rr_arbiter.sv
// logb_rr_arbiter
//   Merges NCH logging channels into one record stream. Each channel pushes
//   into its own FIFO (no ready; overflowing pushes are dropped and flagged),
//   and a round-robin arbiter pops one head per load opportunity into a
//   single registered output stage.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   in_valid/in_data per-channel push strobe and record (channel i at slice i)
//   in_almful        per-channel registered almost-full backpressure
//   out_valid/out_ready/out_data/out_chid  merged output handshake + source id
//   overflow         sticky per-channel drop flag
//   xfer_cnt         free-running count of completed output handshakes
module logb_rr_arbiter #(
  parameter int NCH          = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int ALMFUL_SLACK = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NCH-1:0]            in_valid,
  input  logic [NCH*DATA_WIDTH-1:0] in_data,
  output logic [NCH-1:0]            in_almful,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(NCH)-1:0]    out_chid,
  output logic [NCH-1:0]            overflow,
  output logic [31:0]               xfer_cnt
);

  localparam int CHW = $clog2(NCH);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0]  FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  ALM_LVL  = CW'(FIFO_DEPTH - ALMFUL_SLACK);
  localparam logic [CHW-1:0] LAST_RST = CHW'(NCH - 1);

  logic [DATA_WIDTH-1:0] mem_q [NCH][FIFO_DEPTH];
  logic [CW-1:0]         cnt_q [NCH];
  logic [CW-1:0]         cnt_d [NCH];
  logic [PW-1:0]         wptr_q [NCH];
  logic [PW-1:0]         wptr_d [NCH];
  logic [PW-1:0]         rptr_q [NCH];
  logic [PW-1:0]         rptr_d [NCH];
  logic [NCH-1:0]        push_s, pop_s;
  logic [NCH-1:0]        almful_q, almful_d, overflow_q, overflow_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CHW-1:0]        out_chid_q, out_chid_d;
  logic [CHW-1:0]        last_grant_q, last_grant_d;
  logic [31:0]           xfer_cnt_q, xfer_cnt_d;
  logic                  load_s, grant_found_s;
  logic [CHW-1:0]        grant_idx_s, cand_s;

  // Round-robin search for the first non-empty channel after the last grant.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = last_grant_q;
    cand_s        = last_grant_q;
    for (int k = 0; k < NCH; k++) begin
      cand_s = CHW'((int'(last_grant_q) + 1 + k) % NCH);
      if (!grant_found_s && (cnt_q[cand_s] != {CW{1'b0}})) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Push/pop decisions and per-channel FIFO bookkeeping.
  always_comb begin
    load_s = !out_valid_q || out_ready;
    pop_s  = (load_s && grant_found_s) ? (NCH'(1'b1) << grant_idx_s) : {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      // Fullness is judged before any same-cycle pop, so a full channel drops.
      push_s[i]     = rstn && in_valid[i] && (cnt_q[i] != FULL_LVL);
      cnt_d[i]      = cnt_q[i] + CW'(push_s[i]) - CW'(pop_s[i]);
      wptr_d[i]     = wptr_q[i] + PW'(push_s[i]);
      rptr_d[i]     = rptr_q[i] + PW'(pop_s[i]);
      almful_d[i]   = (cnt_d[i] >= ALM_LVL);
      overflow_d[i] = overflow_q[i] | (in_valid[i] && (cnt_q[i] == FULL_LVL));
    end
  end

  // Output register load: take the granted head, otherwise drain or hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chid_d   = out_chid_q;
    last_grant_d = last_grant_q;
    xfer_cnt_d   = xfer_cnt_q + ((out_valid_q && out_ready) ? 32'd1 : 32'd0);
    if (load_s) begin
      out_valid_d = grant_found_s;
      if (grant_found_s) begin
        out_data_d   = mem_q[grant_idx_s][rptr_q[grant_idx_s]];
        out_chid_d   = grant_idx_s;
        last_grant_d = grant_idx_s;
      end else begin
        last_grant_d = last_grant_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= {CW{1'b0}};
        wptr_q[i] <= {PW{1'b0}};
        rptr_q[i] <= {PW{1'b0}};
      end
      almful_q     <= {NCH{1'b0}};
      overflow_q   <= {NCH{1'b0}};
      out_valid_q  <= 1'b0;
      last_grant_q <= LAST_RST;
      xfer_cnt_q   <= 32'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
      almful_q     <= almful_d;
      overflow_q   <= overflow_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  // Output payload registers are not reset; out_valid qualifies them.
  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
    out_chid_q <= out_chid_d;
  end

  // FIFO storage writes; push_s is already gated by reset and fullness.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push_s[i]) begin
        mem_q[i][wptr_q[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_almful = almful_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chid  = out_chid_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_logb_rr_arbiter.sv
// tb_logb_rr_arbiter
//   Self-checking bench for logb_rr_arbiter: a directed vector table, hand
//   sequences for overflow/backpressure/reset/counter wrap, and randomized
//   traffic compared against a queue-based reference model.
module tb_logb_rr_arbiter;
  localparam int NCH = 4, DW = 32, DEPTH = 16, SLACK = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_almful;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_chid;
  logic [NCH-1:0]    overflow;
  logic [31:0]       xfer_cnt;

  always #5 clk = ~clk;

  logb_rr_arbiter #(.NCH(NCH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALMFUL_SLACK(SLACK)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_almful(in_almful),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chid(out_chid),
    .overflow(overflow), .xfer_cnt(xfer_cnt));

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: one queue per channel plus the output register contents.
  logic [DW-1:0]  mq [NCH][$];
  logic [NCH-1:0] m_ovf, m_alm;
  logic           m_valid;
  logic [DW-1:0]  m_data;
  int             m_chid, m_last;
  logic [31:0]    m_xfer;

  task automatic model_step(input logic [NCH-1:0] iv, input logic [NCH*DW-1:0] idata,
                            input logic ordy, input logic rst);
    int sz [NCH];
    if (!rst) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_ovf = '0; m_alm = '0; m_valid = 1'b0; m_last = NCH - 1; m_xfer = 32'd0;
    end else begin
      for (int i = 0; i < NCH; i++) sz[i] = mq[i].size();
      if (m_valid && ordy) m_xfer = m_xfer + 32'd1;
      if (!m_valid || ordy) begin
        m_valid = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (m_last + k) % NCH;
          if (!m_valid && sz[c] > 0) begin
            m_data = mq[c].pop_front(); m_chid = c; m_last = c; m_valid = 1'b1;
          end
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (iv[i]) begin
          if (sz[i] >= DEPTH) m_ovf[i] = 1'b1;
          else mq[i].push_back(idata[i*DW +: DW]);
        end
      end
      for (int i = 0; i < NCH; i++) m_alm[i] = (mq[i].size() >= DEPTH - SLACK);
    end
  endtask

  task automatic cycle(input logic [NCH-1:0] iv, input logic [NCH*DW-1:0] idata,
                       input logic ordy, input logic rst);
    @(negedge clk);
    in_valid = iv; in_data = idata; out_ready = ordy; rstn = rst;
    @(posedge clk);
    model_step(iv, idata, ordy, rst);
    #1;
  endtask

  task automatic model_check(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check({tag, "_data"}, 64'(out_data), 64'(m_data));
      check({tag, "_chid"}, 64'(out_chid), 64'(m_chid));
    end
    check({tag, "_almful"}, 64'(in_almful), 64'(m_alm));
    check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    check({tag, "_xfer"}, 64'(xfer_cnt), 64'(m_xfer));
  endtask

  function automatic logic [NCH*DW-1:0] slice(input int ch, input logic [DW-1:0] v);
    logic [NCH*DW-1:0] r;
    r = '0;
    r[ch*DW +: DW] = v;
    return r;
  endfunction

  typedef struct {
    logic [NCH-1:0]    iv;
    logic [NCH*DW-1:0] idata;
    logic              ordy;
    logic              rst;
    logic              ev;
    logic [DW-1:0]     ed;
    logic [1:0]        ec;
    logic [31:0]       ex;
  } vec_t;

  function automatic vec_t mkv(input logic [NCH-1:0] iv, input logic [NCH*DW-1:0] idata,
                               input logic rst, input logic ev, input logic [DW-1:0] ed,
                               input logic [1:0] ec, input logic [31:0] ex);
    vec_t v;
    v.iv = iv; v.idata = idata; v.ordy = 1'b1; v.rst = rst;
    v.ev = ev; v.ed = ed; v.ec = ec; v.ex = ex;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [11];
    logic [NCH*DW-1:0] all4;
    int n2, exp_idx;
    logic [NCH-1:0] iv;
    logic [NCH*DW-1:0] rd;

    in_valid = '0; in_data = '0; out_ready = 1'b1; rstn = 1'b0;
    cycle('0, '0, 1'b1, 1'b0);

    // Directed table: single-record latency, then the 4-way same-cycle push.
    all4 = {32'h13, 32'h12, 32'h11, 32'h10};
    tbl[0]  = mkv(4'b0000, '0,               1'b0, 1'b0, 32'h0,  2'd0, 32'd0);
    tbl[1]  = mkv(4'b0001, slice(0, 32'hA0), 1'b1, 1'b0, 32'h0,  2'd0, 32'd0);
    tbl[2]  = mkv(4'b0000, '0,               1'b1, 1'b1, 32'hA0, 2'd0, 32'd0);
    tbl[3]  = mkv(4'b0000, '0,               1'b1, 1'b0, 32'h0,  2'd0, 32'd1);
    tbl[4]  = mkv(4'b0000, '0,               1'b0, 1'b0, 32'h0,  2'd0, 32'd0);
    tbl[5]  = mkv(4'b1111, all4,             1'b1, 1'b0, 32'h0,  2'd0, 32'd0);
    tbl[6]  = mkv(4'b0000, '0,               1'b1, 1'b1, 32'h10, 2'd0, 32'd0);
    tbl[7]  = mkv(4'b0000, '0,               1'b1, 1'b1, 32'h11, 2'd1, 32'd1);
    tbl[8]  = mkv(4'b0000, '0,               1'b1, 1'b1, 32'h12, 2'd2, 32'd2);
    tbl[9]  = mkv(4'b0000, '0,               1'b1, 1'b1, 32'h13, 2'd3, 32'd3);
    tbl[10] = mkv(4'b0000, '0,               1'b1, 1'b0, 32'h0,  2'd0, 32'd4);
    for (int v = 0; v < 11; v++) begin
      cycle(tbl[v].iv, tbl[v].idata, tbl[v].ordy, tbl[v].rst);
      check($sformatf("tbl%0d_valid", v), 64'(out_valid), 64'(tbl[v].ev));
      if (tbl[v].ev) begin
        check($sformatf("tbl%0d_data", v), 64'(out_data), 64'(tbl[v].ed));
        check($sformatf("tbl%0d_chid", v), 64'(out_chid), 64'(tbl[v].ec));
      end
      check($sformatf("tbl%0d_xfer", v), 64'(xfer_cnt), 64'(tbl[v].ex));
      model_check($sformatf("tbl%0d", v));
    end

    // Overflow: park a ch0 record in the stalled output register so the
    // ch2 FIFO alone has to absorb a 17-record burst.
    cycle(4'b0001, slice(0, 32'hC0), 1'b0, 1'b1);
    cycle(4'b0000, '0, 1'b0, 1'b1);
    check("park_valid", 64'(out_valid), 64'd1);
    for (int k = 1; k <= 17; k++) begin
      cycle(4'b0100, slice(2, 32'h200 + 32'(k - 1)), 1'b0, 1'b1);
      check($sformatf("almful2_push%0d", k), 64'(in_almful[2]), 64'(k >= 8));
      check($sformatf("ovf2_push%0d", k), 64'(overflow[2]), 64'(k >= 17));
      model_check("burst");
    end
    check("stall_hold_data", 64'(out_data), 64'h0C0);
    n2 = 0;
    for (int c = 0; c < 40 && out_valid; c++) begin
      if (out_chid == 2'd2) begin
        check($sformatf("drain_order%0d", n2), 64'(out_data), 64'(32'h200 + 32'(n2)));
        n2++;
      end
      cycle('0, '0, 1'b1, 1'b1);
      model_check("drain");
    end
    check("drain_count", 64'(n2), 64'd16);
    check("drain_done", 64'(out_valid), 64'd0);

    // Reset with records buffered; in_valid during reset is ignored.
    cycle(4'b1111, all4, 1'b0, 1'b1);
    cycle(4'b0001, slice(0, 32'h55), 1'b0, 1'b1);
    cycle(4'b1111, all4, 1'b0, 1'b0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_almful", 64'(in_almful), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_xfer", 64'(xfer_cnt), 64'd0);
    cycle('0, '0, 1'b1, 1'b1);
    check("rst_discard", 64'(out_valid), 64'd0);
    cycle(4'b1000, slice(3, 32'h333), 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);
    check("post_rst_ch3_valid", 64'(out_valid), 64'd1);
    check("post_rst_ch3_chid", 64'(out_chid), 64'd3);
    check("post_rst_ch3_data", 64'(out_data), 64'h333);
    cycle('0, '0, 1'b1, 1'b0);
    cycle(4'b1001, slice(0, 32'h300) | slice(3, 32'h3F3), 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);
    check("post_rst_first_chid", 64'(out_chid), 64'd0);
    check("post_rst_first_data", 64'(out_data), 64'h300);
    cycle('0, '0, 1'b1, 1'b1);
    check("post_rst_second_chid", 64'(out_chid), 64'd3);
    model_check("post_rst");
    cycle('0, '0, 1'b1, 1'b1);

    // xfer_cnt wrap from the all-ones state.
    @(negedge clk);
    force dut.xfer_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.xfer_cnt_q;
    m_xfer = 32'hFFFF_FFFF;
    cycle(4'b0010, slice(1, 32'h77), 1'b1, 1'b1);
    check("wrap_pre", 64'(xfer_cnt), 64'hFFFF_FFFF);
    cycle('0, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);
    check("wrap_zero", 64'(xfer_cnt), 64'd0);
    model_check("wrap");

    // Random traffic on ch1/ch3 with random backpressure.
    for (int c = 0; c < 300; c++) begin
      iv = '0;
      iv[1] = ($urandom_range(0, 2) == 0);
      iv[3] = ($urandom_range(0, 2) == 0);
      rd = {$urandom, $urandom, $urandom, $urandom};
      cycle(iv, rd, 1'($urandom_range(0, 1)), 1'b1);
      model_check("rnd13");
    end
    // Random traffic on all channels, pushed hard enough to overflow.
    for (int c = 0; c < 300; c++) begin
      iv = 4'($urandom);
      rd = {$urandom, $urandom, $urandom, $urandom};
      cycle(iv, rd, ($urandom_range(0, 3) == 0), 1'b1);
      model_check("rndall");
    end
    exp_idx = 0;
    for (int c = 0; c < 100; c++) begin
      cycle('0, '0, 1'b1, 1'b1);
      model_check("rnddrain");
      exp_idx++;
    end
    check("rnd_final_empty", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/logb_rr_arbiter.md
LOGB_RR_ARBITER -- requirements
Module: logb_rr_arbiter

Interface
REQ-001 Parameter NCH, default 4, number of logging channels merged (>=2).
REQ-002 Parameter DATA_WIDTH, default 32, logging record width.
REQ-003 Parameter FIFO_DEPTH, default 16, per-channel buffer entries (power of 2, >=4).
REQ-004 Parameter ALMFUL_SLACK, default 8, free entries still remaining when in_almful asserts (< FIFO_DEPTH).
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  NCH  per-channel push strobe; FIFO-style, no ready.
REQ-008 in_data  input  NCH*DATA_WIDTH  channel i record at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_almful  output  NCH  per-channel almost-full backpressure to the channel's logger pipeline.
REQ-010 out_valid  output  1  merged record valid.
REQ-011 out_ready  input  1  storage backend accepts record.
REQ-012 out_data  output  DATA_WIDTH  merged record.
REQ-013 out_chid  output  $clog2(NCH)  source channel of out_data.
REQ-014 overflow  output  NCH  sticky per-channel drop flag.
REQ-015 xfer_cnt  output  32  count of completed output handshakes.

Function
REQ-016 Each channel SHALL own a FIFO of FIFO_DEPTH entries with count register cnt[i] (0..FIFO_DEPTH).
REQ-017 Push: in_valid[i] && cnt[i] < FIFO_DEPTH SHALL write in_data slice at the write pointer at the clock edge.
REQ-018 Full is evaluated on cnt[i] before the same-cycle pop; push at cnt[i]==FIFO_DEPTH SHALL drop the record and set overflow[i], even with a simultaneous pop.
REQ-019 overflow[i] SHALL stay set until reset.
REQ-020 in_almful[i] SHALL be registered: high in cycle t+1 iff cnt[i] after edge t >= FIFO_DEPTH-ALMFUL_SLACK.
REQ-021 Output stage is one register (out_valid/out_data/out_chid); it loads when !out_valid || out_ready.
REQ-022 On load, the arbiter SHALL grant the first channel with cnt>0 in round-robin order starting at (last_grant+1) mod NCH, pop its head, and load it with its index.
REQ-023 last_grant SHALL update only on a grant; its reset value is NCH-1 so channel 0 wins first.
REQ-024 No channel non-empty at a load opportunity: out_valid SHALL go low (if out_ready) or hold.
REQ-025 While out_valid && !out_ready, out_data and out_chid SHALL hold stable and no pop SHALL occur.
REQ-026 Latency: record pushed at edge t into an empty system SHALL appear with out_valid high in cycle t+2.
REQ-027 Full throughput: with out_ready=1 and records available, one record per cycle SHALL be output.
REQ-028 Same-cycle push and pop on one channel SHALL leave cnt unchanged and preserve FIFO order.
REQ-029 Per-channel order SHALL be preserved; no record is duplicated or lost except per REQ-018.
REQ-030 Fairness: a continuously non-empty channel SHALL be granted at least once every NCH grants.
REQ-031 xfer_cnt SHALL increment on out_valid && out_ready and wrap from 2^32-1 to 0.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-033 rstn low at an edge SHALL clear cnt, pointers, out_valid, in_almful, overflow, xfer_cnt, and set last_grant=NCH-1; out_data/out_chid/FIFO storage are not reset.
REQ-034 Reset mid-operation SHALL discard all buffered records; in_valid during reset SHALL be ignored.
REQ-035 First output after reset SHALL come from channel 0 if channel 0 is non-empty.

Verification
REQ-036 Push 0xA0 on ch0 at edge t, out_ready=1 -> out_valid=1, out_data=0xA0, out_chid=0 in cycle t+2; xfer_cnt=1 after.
REQ-037 All 4 channels push one record each same cycle, out_ready=1 -> output order chid 0,1,2,3 on consecutive cycles.
REQ-038 Ch2 pushes 17 records back-to-back, out_ready=0 -> in_almful[2]=1 from cycle after 8th push; 17th dropped, overflow[2]=1; drain yields exactly 16 records in order.
REQ-039 out_ready toggled 1/0 randomly with records on ch1 and ch3 -> data held stable while stalled; ch1/ch3 alternate; no loss.
REQ-040 Reset asserted with 5 records buffered -> next cycle out_valid=0, in_almful=0, overflow=0, xfer_cnt=0; subsequent single ch3 push emerges with chid 3.
REQ-041 Preload xfer_cnt to 2^32-1 via 2^32-1 handshakes (or forced state), one more handshake -> xfer_cnt=0.
